pcie_tag_arbiter: RTL and testbench

Shares the PCIe read-request tag pool among NUM_REQ DMA read requesters. It pops tags from the tag pool on behalf of the round-robin winner and enforces a per-requester outstanding limit. It records tag ownership so each completion can be steered to its requester, and it hands each tag back to the pool on the final completion. It sits between the read DMA channels and the tag pool, on the request side of the PCIe TX engine.

---
 rtl/pcie_tag_arbiter.sv | 143 ++++++++++++++
 tb/tb_pcie_tag_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pcie_tag_arbiter.sv
// Round-robin tag allocator between DMA read requesters and the PCIe tag pool.
// Optional build macro TAG_ARB_RESERVE_EN keeps the last tags for requester 0 while pool_low_i is set.
module pcie_tag_arbiter #(
    parameter int TAG_WIDTH = 8,
    parameter int NUM_REQ   = 4,
    parameter int MAX_OUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_i,
    output logic [NUM_REQ-1:0]   gnt_o,
    output logic [TAG_WIDTH-1:0] gnt_tag_o,
    input  logic [TAG_WIDTH-1:0] pool_tag_i,
    input  logic                 pool_avail_i,
    input  logic                 pool_low_i,
    input  logic                 pool_init_done_i,
    output logic                 pool_pop_o,
    output logic [TAG_WIDTH-1:0] ret_tag_o,
    output logic                 ret_valid_o,
    input  logic                 cpl_valid_i,
    input  logic [TAG_WIDTH-1:0] cpl_tag_i,
    input  logic                 cpl_last_i,
    output logic [NUM_REQ-1:0]   cpl_owner_o,
    output logic                 cpl_owner_valid_o,
    output logic                 err_spurious_o
);

    localparam int TAG_CNT = 1 << TAG_WIDTH;
    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int CNT_W   = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);

    logic [NUM_REQ-1:0]   gnt_q;
    logic [TAG_WIDTH-1:0] gnt_tag_q;
    logic [TAG_WIDTH-1:0] ret_tag_q;
    logic                 ret_valid_q;
    logic [NUM_REQ-1:0]   cpl_owner_q;
    logic                 cpl_owner_valid_q;
    logic                 err_spurious_q;
    logic [IDX_W-1:0]     rr_ptr_q;
    logic [IDX_W-1:0]     rr_ptr_d;
    logic [CNT_W-1:0]     out_cnt_q [NUM_REQ];
    logic [TAG_CNT-1:0]   vld_q;
    logic [IDX_W-1:0]     owner_q [TAG_CNT];

    logic [NUM_REQ-1:0]   elig;
    logic [IDX_W-1:0]     winner;
    logic                 found;
    logic                 grant;
    logic                 reserved;
    logic                 cpl_hit;
    logic                 cpl_ret;
    logic [IDX_W-1:0]     cpl_idx;

    always_comb begin
        elig = req_i & ~gnt_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (out_cnt_q[i] >= MAX_OUT_C) elig[i] = 1'b0;
        end
`ifdef TAG_ARB_RESERVE_EN
        reserved = pool_low_i;
        if (pool_low_i) elig = elig & NUM_REQ'(1);
`else
        reserved = 1'b0;
`endif
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int               idx;
            logic [IDX_W-1:0] idx_l;
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            idx_l = IDX_W'(idx);
            if (!found && elig[idx_l]) begin
                found  = 1'b1;
                winner = idx_l;
            end
        end
        grant = ~rst & pool_init_done_i & pool_avail_i & found;
        rr_ptr_d = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end

`ifndef TAG_ARB_RESERVE_EN
    logic unused_pool_low;
    assign unused_pool_low = pool_low_i;
`endif

    assign cpl_idx    = owner_q[cpl_tag_i];
    assign cpl_hit    = cpl_valid_i & vld_q[cpl_tag_i];
    assign cpl_ret    = cpl_hit & cpl_last_i;
    assign pool_pop_o = grant;

    // Owner table needs no reset: entries are only read while their vld bit is set.
    always_ff @(posedge clk) begin
        if (grant) owner_q[pool_tag_i] <= winner;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q             <= '0;
            gnt_tag_q         <= '0;
            ret_tag_q         <= '0;
            ret_valid_q       <= 1'b0;
            cpl_owner_q       <= '0;
            cpl_owner_valid_q <= 1'b0;
            err_spurious_q    <= 1'b0;
            rr_ptr_q          <= '0;
            vld_q             <= '0;
            for (int i = 0; i < NUM_REQ; i++) out_cnt_q[i] <= '0;
        end else begin
            gnt_q             <= grant ? (NUM_REQ'(1) << winner) : '0;
            cpl_owner_q       <= cpl_hit ? (NUM_REQ'(1) << cpl_idx) : '0;
            cpl_owner_valid_q <= cpl_hit;
            ret_valid_q       <= cpl_ret;
            if (grant) begin
                gnt_tag_q          <= pool_tag_i;
                vld_q[pool_tag_i]  <= 1'b1;
                if (!reserved) rr_ptr_q <= rr_ptr_d;
            end
            if (cpl_ret) begin
                ret_tag_q        <= cpl_tag_i;
                vld_q[cpl_tag_i] <= 1'b0;
            end
            if (cpl_valid_i && !vld_q[cpl_tag_i]) err_spurious_q <= 1'b1;
            // A grant and a final completion for the same requester cancel out.
            for (int i = 0; i < NUM_REQ; i++) begin
                if ((grant && winner == IDX_W'(i)) && !(cpl_ret && cpl_idx == IDX_W'(i)))
                    out_cnt_q[i] <= out_cnt_q[i] + 1'b1;
                else if (!(grant && winner == IDX_W'(i)) && (cpl_ret && cpl_idx == IDX_W'(i)))
                    out_cnt_q[i] <= out_cnt_q[i] - 1'b1;
            end
        end
    end

    assign gnt_o             = gnt_q;
    assign gnt_tag_o         = gnt_tag_q;
    assign ret_tag_o         = ret_tag_q;
    assign ret_valid_o       = ret_valid_q;
    assign cpl_owner_o       = cpl_owner_q;
    assign cpl_owner_valid_o = cpl_owner_valid_q;
    assign err_spurious_o    = err_spurious_q;

endmodule

// File: tb/tb_pcie_tag_arbiter.sv
// Directed bench for pcie_tag_arbiter with MAX_OUT=2; the bench models the pool head as a counter.
module tb_pcie_tag_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [7:0] gnt_tag;
    logic [7:0] pool_tag;
    logic       pool_avail;
    logic       pool_low;
    logic       pool_init_done;
    logic       pool_pop;
    logic [7:0] ret_tag;
    logic       ret_valid;
    logic       cpl_valid;
    logic [7:0] cpl_tag;
    logic       cpl_last;
    logic [3:0] cpl_owner;
    logic       cpl_owner_valid;
    logic       err_spurious;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pcie_tag_arbiter #(.TAG_WIDTH(8), .NUM_REQ(4), .MAX_OUT(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_i            (req),
        .gnt_o            (gnt),
        .gnt_tag_o        (gnt_tag),
        .pool_tag_i       (pool_tag),
        .pool_avail_i     (pool_avail),
        .pool_low_i       (pool_low),
        .pool_init_done_i (pool_init_done),
        .pool_pop_o       (pool_pop),
        .ret_tag_o        (ret_tag),
        .ret_valid_o      (ret_valid),
        .cpl_valid_i      (cpl_valid),
        .cpl_tag_i        (cpl_tag),
        .cpl_last_i       (cpl_last),
        .cpl_owner_o      (cpl_owner),
        .cpl_owner_valid_o(cpl_owner_valid),
        .err_spurious_o   (err_spurious)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    endtask

    // Checks the combinational pop just before the edge, then advances one cycle.
    task automatic step(input string name, input logic exp_pop);
        logic popped;
        #1;
        chk(name, {31'd0, pool_pop}, {31'd0, exp_pop});
        popped = pool_pop;
        @(posedge clk);
        #1;
        if (popped) pool_tag = pool_tag + 8'd1;
    endtask

    task automatic do_reset(input logic [7:0] first_tag);
        rst = 1'b1; req = 4'b0000; cpl_valid = 1'b0; cpl_last = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; pool_tag = first_tag;
    endtask

    initial begin
        rst = 1'b1; req = 4'b1111; pool_tag = 8'h00; pool_avail = 1'b1;
        pool_low = 1'b0; pool_init_done = 1'b1; cpl_valid = 1'b0;
        cpl_tag = 8'h00; cpl_last = 1'b0;
        @(posedge clk); #1;
        step("rst_pop", 1'b0);
        chk("rst_gnt", {28'd0, gnt}, 32'h0);
        chk("rst_gnt_tag", {24'd0, gnt_tag}, 32'h0);
        chk("rst_ret", {23'd0, ret_valid, ret_tag}, 32'h0);
        chk("rst_owner", {27'd0, cpl_owner_valid, cpl_owner}, 32'h0);
        chk("rst_err", {31'd0, err_spurious}, 32'h0);

        // Start-up gating
        rst = 1'b0; pool_init_done = 1'b0; req = 4'b0001; pool_tag = 8'h00;
        step("init_gate_pop", 1'b0);
        step("init_gate_pop2", 1'b0);
        chk("init_gate_gnt", {28'd0, gnt}, 32'h0);
        pool_init_done = 1'b1;
        step("start_pop", 1'b1);
        chk("start_gnt", {28'd0, gnt}, 32'h1);
        chk("start_tag", {24'd0, gnt_tag}, 32'h00);
        req = 4'b0000;
        step("start_idle_pop", 1'b0);
        chk("start_gnt_pulse", {28'd0, gnt}, 32'h0);

        // Fairness, after confirming pool_avail gating
        do_reset(8'h10);
        pool_avail = 1'b0; req = 4'b1111;
        step("avail_gate_pop", 1'b0);
        pool_avail = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step("fair_pop", 1'b1);
            chk("fair_gnt", {28'd0, gnt}, 32'h1 << (k % 4));
            chk("fair_tag", {24'd0, gnt_tag}, 32'h10 + k);
        end
        step("fair_limit_pop", 1'b0);
        chk("fair_limit_gnt", {28'd0, gnt}, 32'h0);

        // Outstanding limit on requester 1
        do_reset(8'h20);
        req = 4'b0010;
        step("lim_pop0", 1'b1);
        chk("lim_gnt0", {20'd0, gnt, gnt_tag}, 32'h2_20);
        step("lim_mask_pop", 1'b0);
        step("lim_pop1", 1'b1);
        chk("lim_gnt1", {20'd0, gnt, gnt_tag}, 32'h2_21);
        step("lim_mask_pop2", 1'b0);
        step("lim_full_pop", 1'b0);
        chk("lim_full_gnt", {28'd0, gnt}, 32'h0);
        cpl_valid = 1'b1; cpl_tag = 8'h21; cpl_last = 1'b0;
        step("lim_partial_pop", 1'b0);
        chk("partial_owner", {27'd0, cpl_owner_valid, cpl_owner}, 32'h12);
        chk("partial_ret", {31'd0, ret_valid}, 32'h0);
        cpl_tag = 8'h20; cpl_last = 1'b1;
        step("lim_last_pop", 1'b0);
        chk("last_ret", {23'd0, ret_valid, ret_tag}, 32'h1_20);
        chk("last_owner", {27'd0, cpl_owner_valid, cpl_owner}, 32'h12);
        cpl_valid = 1'b0; cpl_last = 1'b0;
        step("lim_regrant_pop", 1'b1);
        chk("lim_regrant_gnt", {20'd0, gnt, gnt_tag}, 32'h2_22);
        chk("lim_ret_pulse", {31'd0, ret_valid}, 32'h0);
        step("lim_mask_pop3", 1'b0);
        step("lim_full_pop2", 1'b0);

        // Same-cycle grant and final completion for requester 2
        do_reset(8'h30);
        req = 4'b0100;
        step("same_pop0", 1'b1);
        chk("same_gnt0", {20'd0, gnt, gnt_tag}, 32'h4_30);
        step("same_mask_pop", 1'b0);
        cpl_valid = 1'b1; cpl_tag = 8'h30; cpl_last = 1'b1;
        step("same_pop1", 1'b1);
        chk("same_gnt1", {20'd0, gnt, gnt_tag}, 32'h4_31);
        chk("same_ret", {23'd0, ret_valid, ret_tag}, 32'h1_30);
        chk("same_owner", {27'd0, cpl_owner_valid, cpl_owner}, 32'h14);
        cpl_valid = 1'b0; cpl_last = 1'b0;
        step("same_mask_pop2", 1'b0);
        step("same_pop2", 1'b1);
        chk("same_gnt2", {20'd0, gnt, gnt_tag}, 32'h4_32);
        step("same_mask_pop3", 1'b0);
        step("same_full_pop", 1'b0);

        // Spurious completion
        do_reset(8'h40);
        cpl_valid = 1'b1; cpl_tag = 8'h7F; cpl_last = 1'b1;
        step("spur_pop", 1'b0);
        chk("spur_err", {31'd0, err_spurious}, 32'h1);
        chk("spur_owner_valid", {31'd0, cpl_owner_valid}, 32'h0);
        chk("spur_ret", {31'd0, ret_valid}, 32'h0);
        cpl_valid = 1'b0; cpl_last = 1'b0;
        step("spur_idle_pop", 1'b0);
        step("spur_idle_pop2", 1'b0);
        chk("spur_sticky", {31'd0, err_spurious}, 32'h1);
        do_reset(8'h50);
        chk("spur_cleared", {31'd0, err_spurious}, 32'h0);

        // pool_low reservation
        pool_low = 1'b1; req = 4'b0110;
`ifdef TAG_ARB_RESERVE_EN
        step("rsv_block_pop", 1'b0);
        step("rsv_block_pop2", 1'b0);
        chk("rsv_block_gnt", {28'd0, gnt}, 32'h0);
        req = 4'b0111;
        step("rsv_r0_pop", 1'b1);
        chk("rsv_r0_gnt", {20'd0, gnt, gnt_tag}, 32'h1_50);
`else
        step("low_r1_pop", 1'b1);
        chk("low_r1_gnt", {20'd0, gnt, gnt_tag}, 32'h2_50);
        step("low_r2_pop", 1'b1);
        chk("low_r2_gnt", {20'd0, gnt, gnt_tag}, 32'h4_51);
`endif
        pool_low = 1'b0; req = 4'b0000;
        step("end_pop", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
